imuldiv_muldiv_issue_ctrl: RTL and testbench

//  Initiator-side controller for the muldivreq/muldivresp val/rdy interface. Takes

---
 rtl/imuldiv_muldiv_issue_ctrl.sv | 133 +++++++++++++
 tb/tb_imuldiv_muldiv_issue_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imuldiv_muldiv_issue_ctrl.sv
// Issue controller for the muldiv unit: forwards commands, tracks destination tags
// in an in-order FIFO and turns each response into one registered writeback beat.
module imuldiv_muldiv_issue_ctrl #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_val,
  output logic             cmd_rdy,
  input  logic [2:0]       cmd_fn,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [4:0]       cmd_dest,
  input  logic             cmd_sel_hi,
  output logic [2:0]       muldivreq_msg_fn,
  output logic [31:0]      muldivreq_msg_a,
  output logic [31:0]      muldivreq_msg_b,
  output logic             muldivreq_val,
  input  logic             muldivreq_rdy,
  input  logic [63:0]      muldivresp_msg_result,
  input  logic             muldivresp_val,
  output logic             muldivresp_rdy,
  output logic             wb_val,
  input  logic             wb_rdy,
  output logic [4:0]       wb_dest,
  output logic [31:0]      wb_data,
  output logic [CNT_W-1:0] outstanding,
  output logic             err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [4:0] dest;
    logic       sel_hi;
  } tag_t;

  tag_t              fifo_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wb_val_q, wb_val_d;
  logic [4:0]        wb_dest_q, wb_dest_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              err_q, err_d;

  logic full, empty, push, resp_fire, pop;
  tag_t head, new_tag;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full/empty come from the registered count so no ready depends on a same-cycle response.
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

  assign muldivreq_msg_fn = cmd_fn;
  assign muldivreq_msg_a  = cmd_a;
  assign muldivreq_msg_b  = cmd_b;
  assign muldivreq_val    = cmd_val & ~full;
  assign cmd_rdy          = muldivreq_rdy & ~full;
  assign push             = cmd_val & cmd_rdy;

  assign muldivresp_rdy = ~wb_val_q | wb_rdy;
  assign resp_fire      = muldivresp_val & muldivresp_rdy;
  assign pop            = resp_fire & ~empty;

  assign head    = fifo_q[rptr_q];
  assign new_tag = '{dest: cmd_dest, sel_hi: cmd_sel_hi};

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    wb_val_d  = wb_val_q;
    wb_dest_d = wb_dest_q;
    wb_data_d = wb_data_q;
    err_d     = err_q;

    if (push) wptr_d = ptr_inc(wptr_q);
    if (pop)  rptr_d = ptr_inc(rptr_q);

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (resp_fire && empty) err_d = 1'b1;

    // A new response reloads the beat even while the old one is being consumed.
    if (pop) begin
      wb_val_d  = 1'b1;
      wb_dest_d = head.dest;
      wb_data_d = head.sel_hi ? muldivresp_msg_result[63:32] : muldivresp_msg_result[31:0];
    end else if (wb_val_q && wb_rdy) begin
      wb_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      wb_val_q  <= 1'b0;
      wb_dest_q <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      wb_val_q  <= wb_val_d;
      wb_dest_q <= wb_dest_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= new_tag;
  end

  assign wb_val      = wb_val_q;
  assign wb_dest     = wb_dest_q;
  assign wb_data     = wb_data_q;
  assign outstanding = cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_imuldiv_muldiv_issue_ctrl.sv
// Randomized scoreboard bench for imuldiv_muldiv_issue_ctrl with a behavioural muldiv unit model.
module tb_imuldiv_muldiv_issue_ctrl;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_val = 1'b0;
  logic        cmd_rdy;
  logic [2:0]  cmd_fn = '0;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic [4:0]  cmd_dest = '0;
  logic        cmd_sel_hi = 1'b0;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a;
  logic [31:0] muldivreq_msg_b;
  logic        muldivreq_val;
  logic        muldivreq_rdy = 1'b0;
  logic [63:0] muldivresp_msg_result = '0;
  logic        muldivresp_val = 1'b0;
  logic        muldivresp_rdy;
  logic        wb_val;
  logic        wb_rdy = 1'b0;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic [1:0]  outstanding;
  logic        err;

  imuldiv_muldiv_issue_ctrl #(.DEPTH(DEPTH), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_fn(cmd_fn), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_dest(cmd_dest), .cmd_sel_hi(cmd_sel_hi),
    .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
    .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val), .muldivreq_rdy(muldivreq_rdy),
    .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val),
    .muldivresp_rdy(muldivresp_rdy),
    .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_dest(wb_dest), .wb_data(wb_data),
    .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Stimulus knobs: 0 = force low, 1 = force high, 2 = random
  int   req_mode = 1;
  int   wb_mode = 1;
  bit   resp_en = 1'b0;
  bit   resp_always = 1'b1;
  bit   err_inject = 1'b0;

  // Scoreboard state
  logic [36:0] exp_q[$];
  logic [63:0] pend[$];
  int          m_out = 0;
  int          m_wb = 0;
  bit          m_err = 1'b0;
  bit          hold_prev = 1'b0;
  logic [4:0]  hd;
  logic [31:0] hdat;
  bit          resp_fired = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] q, r;
    case (fn)
      3'd0: return {32'b0, a} * {32'b0, b};
      3'd1: begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: return {a ^ b, a + b};
    endcase
  endfunction

  // Muldiv unit model and ready generators
  always @(posedge clk) begin
    bit held;
    #2;
    muldivreq_rdy = (req_mode == 2) ? ($urandom_range(0, 3) != 0) : (req_mode == 1);
    wb_rdy        = (wb_mode == 2) ? ($urandom_range(0, 3) != 0) : (wb_mode == 1);
    if (err_inject) begin
      muldivresp_val        = 1'b1;
      muldivresp_msg_result = {$urandom, $urandom};
    end else begin
      held = muldivresp_val && !resp_fired;
      if (resp_en && pend.size() > 0 && (held || resp_always || $urandom_range(0, 2) == 0)) begin
        muldivresp_val        = 1'b1;
        muldivresp_msg_result = pend[0];
      end else begin
        muldivresp_val = 1'b0;
      end
    end
  end

  // Monitor: compares DUT state against the model, then advances the model by this cycle's fires
  always @(negedge clk) begin
    bit rf, sf, tk;
    logic [63:0] res;
    logic [36:0] e;
    if (!reset) begin
      m_out = 0; m_wb = 0; m_err = 1'b0; hold_prev = 1'b0; resp_fired = 1'b0;
      exp_q.delete();
      pend.delete();
    end else begin
      chk("outstanding", 72'(outstanding), 72'(m_out));
      chk("err", 72'(err), 72'(m_err));
      chk("wb_val", 72'(wb_val), 72'(m_wb != 0));
      chk("cmd_rdy", 72'(cmd_rdy), 72'(muldivreq_rdy && m_out != DEPTH));
      chk("req_val", 72'(muldivreq_val), 72'(cmd_val && m_out != DEPTH));
      chk("resp_rdy", 72'(muldivresp_rdy), 72'(!wb_val || wb_rdy));
      if (hold_prev) chk("wb_hold", 72'({wb_val, wb_dest, wb_data}), 72'({1'b1, hd, hdat}));

      rf = cmd_val && cmd_rdy;
      sf = muldivresp_val && muldivresp_rdy;
      tk = wb_val && wb_rdy;

      if (tk) begin
        if (exp_q.size() == 0) chk("wb_extra", 72'(1), 72'(0));
        else begin
          e = exp_q.pop_front();
          chk("wb_beat", 72'({wb_dest, wb_data}), 72'(e));
        end
      end

      if (sf) begin
        if (m_out > 0) begin
          m_out--;
          if (pend.size() > 0) res = pend.pop_front();
          m_wb = 1;
        end else begin
          m_err = 1'b1;
          if (tk) m_wb = 0;
        end
      end else if (tk) begin
        m_wb = 0;
      end

      if (rf) begin
        res = ref_res(cmd_fn, cmd_a, cmd_b);
        exp_q.push_back({cmd_dest, cmd_sel_hi ? res[63:32] : res[31:0]});
        pend.push_back(res);
        chk("req_msg", 72'({muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b}),
            72'({cmd_fn, cmd_a, cmd_b}));
        m_out++;
      end

      hold_prev  = wb_val && !wb_rdy;
      hd         = wb_dest;
      hdat       = wb_data;
      resp_fired = sf;
    end
  end

  // Called and returns just after a posedge; holds the command until it is accepted.
  task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic s);
    bit fired;
    fired = 1'b0;
    cmd_fn = fn; cmd_a = a; cmd_b = b; cmd_dest = d; cmd_sel_hi = s;
    cmd_val = 1'b1;
    for (int unsigned n = 0; n < 500; n++) begin
      @(negedge clk);
      if (cmd_val && cmd_rdy) begin
        fired = 1'b1;
        break;
      end
    end
    if (!fired) chk("cmd_accept_timeout", 72'(0), 72'(1));
    @(posedge clk); #1;
    cmd_val = 1'b0;
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_wb(input string name, input logic [4:0] d, input logic [31:0] data);
    bit seen;
    seen = 1'b0;
    for (int unsigned n = 0; n < 50; n++) begin
      @(negedge clk);
      if (wb_val) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) chk(name, 72'({wb_dest, wb_data}), 72'({d, data}));
    else chk({name, "_timeout"}, 72'(0), 72'(1));
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int unsigned n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && outstanding == '0 && !wb_val) begin
        idle = 1'b1;
        break;
      end
    end
    chk("drain", 72'(idle), 72'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    cyc(3);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_outstanding", 72'(outstanding), 72'(0));
    chk("rst_wb", 72'({wb_val, wb_dest, wb_data}), 72'(0));
    chk("rst_err", 72'(err), 72'(0));
    cyc(1);

    // Directed: mul low word, then signed div remainder
    req_mode = 1; wb_mode = 1; resp_en = 1'b1; resp_always = 1'b1;
    issue(3'd0, 32'd8, 32'd3, 5'd5, 1'b0);
    wait_wb("mul_lo", 5'd5, 32'h0000_0018);
    issue(3'd1, 32'hFFFF_FFF6, 32'd3, 5'd7, 1'b1);
    wait_wb("div_rem", 5'd7, 32'hFFFF_FFFF);
    wait_idle();

    // Three back-to-back commands against a stalled unit
    resp_en = 1'b0;
    issue(3'd2, 32'h1111_0000, 32'h0000_2222, 5'd1, 1'b0);
    issue(3'd2, 32'h3333_0000, 32'h0000_4444, 5'd2, 1'b1);
    fork
      issue(3'd0, 32'd100, 32'd7, 5'd3, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("full_cmd_rdy", 72'(cmd_rdy), 72'(0));
          chk("full_outstanding", 72'(outstanding), 72'(2));
        end
        @(posedge clk); #1;
        resp_en = 1'b1;
      end
    join
    wait_idle();

    // Writeback backpressure with a second response waiting
    wb_mode = 0;
    issue(3'd0, 32'h0001_0000, 32'h0001_0000, 5'd9, 1'b1);
    issue(3'd1, 32'd1000, 32'd7, 5'd10, 1'b0);
    cyc(3);
    repeat (5) @(negedge clk);
    chk("bp_resp_rdy", 72'(muldivresp_rdy), 72'(0));
    chk("bp_resp_val", 72'(muldivresp_val), 72'(1));
    chk("bp_wb_val", 72'(wb_val), 72'(1));
    chk("bp_outstanding", 72'(outstanding), 72'(1));
    @(posedge clk); #1;
    wb_mode = 1;
    wait_idle();

    // Response with nothing outstanding
    resp_en = 1'b0;
    err_inject = 1'b1;
    cyc(1);
    err_inject = 1'b0;
    cyc(3);
    @(negedge clk);
    chk("err_sticky", 72'({err, wb_val}), 72'({1'b1, 1'b0}));
    @(posedge clk); #1;

    // Reset with two in flight and a held beat
    wb_mode = 0; resp_en = 1'b1;
    issue(3'd0, 32'd6, 32'd7, 5'd11, 1'b0);
    cyc(4);
    resp_en = 1'b0;
    issue(3'd0, 32'd2, 32'd2, 5'd12, 1'b0);
    issue(3'd0, 32'd3, 32'd3, 5'd13, 1'b0);
    @(negedge clk);
    chk("pre_rst", 72'({outstanding, wb_val}), 72'({2'd2, 1'b1}));
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", 72'({outstanding, wb_val, err, wb_dest, wb_data}), 72'(0));
    chk("mid_rst_cmd_rdy", 72'(cmd_rdy), 72'(muldivreq_rdy));
    @(posedge clk); #1;

    // Randomized traffic
    req_mode = 2; wb_mode = 2; resp_en = 1'b1; resp_always = 1'b0;
    for (int unsigned i = 0; i < 200; i++) begin
      issue(3'($urandom_range(0, 2)), $urandom, 32'($urandom_range(1, 1000)),
            5'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) cyc($urandom_range(1, 4));
    end
    wb_mode = 1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
